flap_cmd_uart_rx: RTL and testbench

Serial command receiver on the game's input side. It takes an 8N1 UART bitstream on one dedicated input pin and recovers bytes. It decodes those bytes into single-cycle game-control strobes: flap, pause toggle and game reset. The top-level wires one bit of ui_in into rx_i and feeds the strobes to the bird physics and game state logic, so the game can be driven by a host as well as by the push-button.

---
 rtl/flap_cmd_uart_rx.sv | 146 ++++++++++++++
 tb/tb_flap_cmd_uart_rx.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flap_cmd_uart_rx.sv
// 8N1 UART receiver that turns host command bytes into one-cycle game strobes (flap, game reset) and a pause level.
// Strobes appear one cycle after the mid-stop-bit sample; there is no backpressure, and each byte is reported exactly once.
module flap_cmd_uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 218,
  parameter logic [7:0]  CMD_FLAP     = 8'h46,
  parameter logic [7:0]  CMD_PAUSE    = 8'h50,
  parameter logic [7:0]  CMD_RESET    = 8'h52
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       rx_i,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       flap_pulse,
  output logic       game_rst_pulse,
  output logic       pause_o,
  output logic       busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_sync1;
  logic          r_rx_s;
  logic          r_rx_prev;
  logic          w_fall;
  logic          w_cnt_last;

  // The synchronizer resets to the idle-high level so that reset never fakes a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= rx_i;
      r_rx_s    <= r_sync1;
      r_rx_prev <= r_rx_s;
    end
  end

  assign w_fall     = r_rx_prev & ~r_rx_s;
  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign busy       = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_bit          <= '0;
      r_shift        <= '0;
      rx_data        <= '0;
      rx_valid       <= 1'b0;
      frame_err      <= 1'b0;
      flap_pulse     <= 1'b0;
      game_rst_pulse <= 1'b0;
      pause_o        <= 1'b0;
    end else begin
      rx_valid       <= 1'b0;
      frame_err      <= 1'b0;
      flap_pulse     <= 1'b0;
      game_rst_pulse <= 1'b0;
      if (!ena) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_bit   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_cnt <= '0;
            if (w_fall) begin
              r_state <= S_START;
            end
          end
          S_START: begin
            if (r_cnt == CNT_HALF) begin
              r_cnt <= '0;
              r_bit <= '0;
              // A line that is high again at mid-start was only a glitch.
              r_state <= r_rx_s ? S_IDLE : S_DATA;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          S_DATA: begin
            if (w_cnt_last) begin
              r_cnt          <= '0;
              r_shift[r_bit] <= r_rx_s;
              if (r_bit == 3'd7) begin
                r_state <= S_STOP;
              end else begin
                r_bit <= r_bit + 3'd1;
              end
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          S_STOP: begin
            if (w_cnt_last) begin
              r_cnt <= '0;
              if (r_rx_s) begin
                rx_data        <= r_shift;
                rx_valid       <= 1'b1;
                flap_pulse     <= (r_shift == CMD_FLAP);
                game_rst_pulse <= (r_shift == CMD_RESET);
                pause_o        <= pause_o ^ (r_shift == CMD_PAUSE);
                r_state        <= S_IDLE;
              end else begin
                frame_err <= 1'b1;
                r_state   <= S_BREAK;
              end
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          S_BREAK: begin
            r_cnt <= '0;
            if (r_rx_s) begin
              r_state <= S_IDLE;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_flap_cmd_uart_rx.sv
// Directed bench for flap_cmd_uart_rx: a byte-level reference model predicts every strobe and level.
module tb_flap_cmd_uart_rx;

  localparam int CPB = 16;
  localparam int TOL = 2;
  // Two synchronizer flops, one edge-detect cycle, half a bit to the start centre and nine bits to the stop centre.
  localparam int LAT = 3 + CPB / 2 + 9 * CPB;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       rx_i;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       flap_pulse;
  logic       game_rst_pulse;
  logic       pause_o;
  logic       busy;

  flap_cmd_uart_rx #(
    .CLKS_PER_BIT(CPB),
    .CMD_FLAP(8'h46),
    .CMD_PAUSE(8'h50),
    .CMD_RESET(8'h52)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .rx_i(rx_i),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .frame_err(frame_err),
    .flap_pulse(flap_pulse),
    .game_rst_pulse(game_rst_pulse),
    .pause_o(pause_o),
    .busy(busy)
  );

  typedef struct {
    logic [7:0] b;
    bit         good;
    int         start;
    int         due;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        e;
  logic [7:0] m_data;
  logic       m_pause;
  int         cyc;
  int         n_cmp;
  int         n_bad;
  int         n_valid;
  int         n_ferr;
  int         n_flap;
  int         n_grst;
  int         last_lat;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // Reference: each sent frame becomes one expected event; good frames update data/pause.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_outputs", {rx_data, rx_valid, frame_err, flap_pulse, game_rst_pulse, pause_o, busy}, 32'd0);
    end else begin
      if (rx_valid) n_valid++;
      if (frame_err) n_ferr++;
      if (flap_pulse) n_flap++;
      if (game_rst_pulse) n_grst++;
      if (rx_valid | frame_err | flap_pulse | game_rst_pulse) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {rx_valid, frame_err, flap_pulse, game_rst_pulse}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          last_lat = cyc - e.start;
          chk("strobe_time", (cyc >= e.due - TOL && cyc <= e.due + TOL), 1);
          if (e.good) begin
            m_data  = e.b;
            m_pause = m_pause ^ (e.b == 8'h50);
            chk("rx_valid", rx_valid, 1);
            chk("frame_err", frame_err, 0);
            chk("flap_pulse", flap_pulse, (e.b == 8'h46));
            chk("game_rst_pulse", game_rst_pulse, (e.b == 8'h52));
          end else begin
            chk("frame_err", frame_err, 1);
            chk("rx_valid_on_err", rx_valid, 0);
            chk("cmd_on_err", {flap_pulse, game_rst_pulse}, 0);
          end
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].due + TOL) begin
        chk("strobe_missing", 0, 1);
        void'(exp_q.pop_front());
      end
      chk("rx_data_level", rx_data, m_data);
      chk("pause_level", pause_o, m_pause);
    end
  end

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // abort_kind: 0 none, 1 reset in mid bit 3, 2 ena low in mid bit 3.
  task automatic drive_frame(input logic [7:0] b, input int stop_low_bits, input int abort_kind);
    logic [9:0] fr;
    ev_t        ev;
    int         bi;
    fr = {1'b1, b, 1'b0};
    if (abort_kind == 0) begin
      ev.b = b;
      ev.good = (stop_low_bits == 0);
      ev.start = cyc;
      ev.due = cyc + LAT;
      exp_q.push_back(ev);
    end
    for (int t = 0; t < 10 * CPB; t++) begin
      bi = t / CPB;
      if (abort_kind == 1 && t == 4 * CPB + CPB / 2) begin
        exp_q.delete();
        m_data = 8'h00;
        m_pause = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outputs", {rx_data, rx_valid, frame_err, flap_pulse, game_rst_pulse, pause_o, busy}, 32'd0);
        return;
      end
      if (abort_kind == 2 && t == 4 * CPB + CPB / 2) begin
        ena = 1'b0;
        @(posedge clk);
        #1;
        chk("ena_low_busy", busy, 0);
        chk("ena_low_pause_held", pause_o, 1);
        return;
      end
      rx_i = (bi == 9) ? (stop_low_bits == 0) : fr[bi];
      @(posedge clk);
      #1;
    end
    if (stop_low_bits > 1) begin
      repeat ((stop_low_bits - 1) * CPB) begin
        @(posedge clk);
        #1;
      end
    end
    rx_i = 1'b1;
  endtask

  int v0, f0, fl0, g0;

  task automatic snap();
    v0 = n_valid;
    f0 = n_ferr;
    fl0 = n_flap;
    g0 = n_grst;
  endtask

  initial begin
    cyc = 0; n_cmp = 0; n_bad = 0;
    n_valid = 0; n_ferr = 0; n_flap = 0; n_grst = 0; last_lat = 0;
    m_data = 8'h00; m_pause = 1'b0;
    rst_n = 1'b0; ena = 1'b1; rx_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_busy", busy, 0);
    chk("reset_pause", pause_o, 0);
    rst_n = 1'b1;
    idle(5);

    snap();
    drive_frame(8'h46, 0, 0);
    idle(4);
    chk("flap_valid_cnt", n_valid - v0, 1);
    chk("flap_cnt", n_flap - fl0, 1);
    chk("flap_ferr_cnt", n_ferr - f0, 0);
    chk("flap_rx_data", rx_data, 8'h46);
    // 10 bit times less the half stop bit, plus three cycles of input pipeline: 155.
    chk("flap_latency", (last_lat >= 152 && last_lat <= 158), 1);

    snap();
    drive_frame(8'h50, 0, 0);
    chk("pause_after_P1", pause_o, 1);
    drive_frame(8'h41, 0, 0);
    chk("pause_after_A", pause_o, 1);
    drive_frame(8'h50, 0, 0);
    chk("pause_after_P2", pause_o, 0);
    idle(4);
    chk("pause_seq_valid_cnt", n_valid - v0, 3);
    chk("pause_seq_rx_data", rx_data, 8'h50);

    snap();
    drive_frame(8'h52, 3, 0);
    idle(10);
    chk("break_ferr_cnt", n_ferr - f0, 1);
    chk("break_valid_cnt", n_valid - v0, 0);
    chk("break_grst_cnt", n_grst - g0, 0);
    chk("break_rx_data", rx_data, 8'h50);
    chk("break_busy", busy, 0);

    snap();
    drive_frame(8'h52, 0, 0);
    idle(4);
    chk("grst_cnt", n_grst - g0, 1);
    chk("grst_rx_data", rx_data, 8'h52);

    snap();
    rx_i = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("glitch_busy_high", busy, 1);
    idle(20);
    chk("glitch_busy_low", busy, 0);
    chk("glitch_no_strobes", (n_valid - v0) + (n_ferr - f0), 0);

    drive_frame(8'hA5, 0, 0);
    idle(4);
    chk("a5_rx_data", rx_data, 8'hA5);

    snap();
    drive_frame(8'h46, 0, 1);
    rx_i = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    idle(8);
    chk("rst_abort_no_flap", n_flap - fl0, 0);

    drive_frame(8'h50, 0, 0);
    idle(4);
    chk("pause_before_ena", pause_o, 1);

    snap();
    drive_frame(8'h46, 0, 2);
    rx_i = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    ena = 1'b1;
    idle(8);
    chk("ena_abort_no_strobe", (n_valid - v0) + (n_flap - fl0), 0);
    chk("ena_abort_rx_data", rx_data, 8'h50);

    snap();
    drive_frame(8'h46, 0, 0);
    idle(20);
    chk("final_flap_cnt", n_flap - fl0, 1);
    chk("final_pause", pause_o, 1);
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
